nmea_uart_rx: RTL and testbench
===============================

// Module: nmea_uart_rx
// PURPOSE
//  UART receiver for the GPS module's NMEA serial stream; upstream stage of the $GPRMC fix detector.
//  Synchronises the asynchronous rx line, samples 8N1 frames with OVERSAMPLE-x timing and presents each
//  good byte as rx_data plus a one-clk rx_valid strobe. Framing errors are flagged and the byte is dropped.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency, Hz
//  BAUD        9600         serial bit rate
//  OVERSAMPLE  16           sample ticks per bit; even, >=8
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  rx         in   1  raw serial line, idle high, asynchronous to clk
//  rx_data    out  8  last good byte, LSB received first
//  rx_valid   out  1  one-clk strobe: rx_data updated this cycle
//  frame_err  out  1  one-clk strobe: stop bit sampled low
//  busy       out  1  high from start-edge detection until return to IDLE
//  parity_err out  1  one-clk strobe: parity mismatch (present only with UART_RX_PARITY_EN)
// BEHAVIOUR
//  - Reset (clk, rst sync active-high): rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, parity_err=0;
//    sync flops=1; state=WAIT_HIGH. rst mid-frame aborts the frame with no strobe.
//  - rx passes a 2-flop synchroniser; all decisions use the synchronised value rx_s.
//  - Tick: DIV = CLK_HZ/(BAUD*OVERSAMPLE), truncated, min 1. Divider counts 0..DIV-1, emits 1-clk tick at
//    DIV-1; cleared on start-edge detection so sampling aligns to the edge.
//  - States:
//    WAIT_HIGH: wait for rx_s==1, then IDLE (prevents a line held low at reset/break from posing as start).
//    IDLE: rx_s==0 -> START, busy=1, tick counter cleared.
//    START: after OVERSAMPLE/2 ticks sample rx_s; 1 -> false start, IDLE, no strobe; 0 -> DATA.
//    DATA: every OVERSAMPLE ticks sample one bit into shift reg, LSB first; after 8 bits -> STOP
//          (or PARITY with macro).
//    STOP: after OVERSAMPLE ticks sample rx_s; 1 -> rx_data<=shift, rx_valid=1 for one clk, IDLE;
//          0 -> frame_err=1 for one clk, rx_data unchanged, WAIT_HIGH.
//  - busy=0 in WAIT_HIGH and IDLE, 1 elsewhere.
//  - Latency: rx_valid rises <= 2 (sync) + 1 clk after the mid-stop-bit sample, i.e. ~9.5 bit times
//    after the start edge. rx_data holds its value until the next good byte.
//  - Back-to-back frames: next start edge may follow the stop-bit sample directly; IDLE detects it with
//    no lost byte. rx_valid and frame_err never assert together.
//  - Stop-bit sample taken at mid-bit; the remaining half stop bit is not checked.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1. PARITY state after bit 7 samples one more bit at mid-bit;
//    if (^shift ^ bit) != 0 -> parity_err one clk, no rx_valid, still proceeds to STOP (stop checked,
//    frame_err may follow on a later cycle). parity_err port exists.
//  Not defined: frame is 8N1, no PARITY state, parity_err port absent.
// TESTING (sim: CLK_HZ=1_536_000, BAUD=9600, OVERSAMPLE=16 -> DIV=10, 160 clk/bit)
//  1. Send 0x24 ('$') 8N1 -> exactly one rx_valid, rx_data=0x24, within 1525 clk of start edge; busy
//     then 0.
//  2. Send "$GPRMC" back-to-back, no idle gap -> 6 rx_valid strobes, bytes 24 47 50 52 4D 43 in order.
//  3. Low glitch of 40 clk on idle line -> no rx_valid, no frame_err; busy pulses then returns to 0.
//  4. Send 0x41 with stop bit 0, hold line low 2000 clk -> one frame_err, no rx_valid, rx_data
//     unchanged; no further events; after line high, 0x56 received normally.
//  5. Assert rst for 1 clk during data bit 4 of 0x41 -> outputs reset to 0, no strobe for that frame;
//     next full 0x41 received correctly.
//  6. (UART_RX_PARITY_EN) 0x41 with parity bit 0 -> rx_valid, 0x41; with parity bit 1 -> parity_err,
//     no rx_valid.

Source files
------------

// File: rtl/nmea_uart_rx.sv
// UART receiver for the NMEA serial stream: 2-flop synchroniser, oversampled 8N1 framing, one-clk strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames; this adds the PARITY state and the parity_err port.
module nmea_uart_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W  = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state_reg;
    logic                rx_meta_reg;
    logic                rx_s;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic [2:0]          bit_cnt_reg;
    logic [7:0]          shift_reg;
    logic                tick;
    logic                half_bit;
    logic                full_bit;
`ifdef UART_RX_PARITY_EN
    logic                par_bad_reg;
`endif

    assign tick     = (div_cnt_reg == DIV_W'(DIV - 1));
    assign half_bit = tick && (tick_cnt_reg == TICK_W'(OVERSAMPLE / 2 - 1));
    assign full_bit = tick && (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s        <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s        <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= WAIT_HIGH;
            div_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg  <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
            if (tick && state_reg != IDLE && state_reg != WAIT_HIGH)
                tick_cnt_reg <= tick_cnt_reg + 1'b1;

            case (state_reg)
                WAIT_HIGH: begin
                    busy <= 1'b0;
                    if (rx_s)
                        state_reg <= IDLE;
                end
                IDLE: begin
                    // Restart the divider on the edge so every sample lands mid-bit.
                    if (!rx_s) begin
                        state_reg    <= START;
                        busy         <= 1'b1;
                        div_cnt_reg  <= '0;
                        tick_cnt_reg <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_reg  <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (half_bit) begin
                        tick_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        if (rx_s) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (full_bit) begin
                        tick_cnt_reg <= '0;
                        shift_reg    <= {rx_s, shift_reg[7:1]};
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (full_bit) begin
                        tick_cnt_reg <= '0;
                        par_bad_reg  <= ^shift_reg ^ rx_s;
                        parity_err   <= ^shift_reg ^ rx_s;
                        state_reg    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (full_bit) begin
                        tick_cnt_reg <= '0;
                        busy         <= 1'b0;
                        if (rx_s) begin
                            state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (!par_bad_reg) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end
`else
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
`endif
                        end else begin
                            state_reg <= WAIT_HIGH;
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= WAIT_HIGH;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nmea_uart_rx.sv
// Scoreboard bench for nmea_uart_rx: expected bytes are queued as frames are driven, popped on rx_valid.
module tb_nmea_uart_rx;
    localparam int CLK_HZ  = 1_536_000;
    localparam int BAUD    = 9600;
    localparam int OS      = 16;
    localparam int BIT_CLK = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    int         par_cnt  = 0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int frame_cnt = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] msg[6] = '{8'h24, 8'h47, 8'h50, 8'h52, 8'h4D, 8'h43};

    nmea_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .busy(busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [7:0] exp;
        if (rx_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rx_valid: got rx_data=%02h, required no strobe", rx_data);
            end else begin
                exp = exp_q.pop_front();
                if (rx_data !== exp) begin
                    errors++;
                    $display("FAIL rx_byte: got %02h, required %02h", rx_data, exp);
                end else begin
                    $display("rx byte %02h ok at cycle %0d", rx_data, cyc);
                end
            end
        end
        if (frame_err) begin
            frame_cnt++;
            $display("frame_err strobe at cycle %0d", cyc);
        end
`ifdef UART_RX_PARITY_EN
        if (parity_err) begin
            par_cnt++;
            $display("parity_err strobe at cycle %0d", cyc);
        end
`endif
        if (rx_valid && frame_err) begin
            checks++;
            errors++;
            $display("FAIL valid_and_frame_err: both asserted, required exclusive");
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^d ^ par_flip;
        repeat (BIT_CLK) @(negedge clk);
`endif
        rx = stop_b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got data=%02h valid=%b ferr=%b busy=%b, required 00 0 0 0",
                     rx_data, rx_valid, frame_err, busy);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_single_byte();
        int v0 = valid_cnt;
        int lat;
        exp_q.push_back(8'h24);
        send_frame(8'h24, 1'b1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        lat = last_valid_cyc - start_cyc;
        checks++;
        if (valid_cnt - v0 != 1) begin
            errors++;
            $display("FAIL single_count: got %0d strobes, required 1", valid_cnt - v0);
        end
        checks++;
        if (valid_cnt - v0 == 1 && (lat > 1525 || lat < 1440)) begin
            errors++;
            $display("FAIL single_latency: got %0d clk, required 1440..1525", lat);
        end
        checks++;
        if (busy !== 1'b0 || rx_data !== 8'h24) begin
            errors++;
            $display("FAIL single_after: got busy=%b data=%02h, required 0 24", busy, rx_data);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        foreach (msg[i]) exp_q.push_back(msg[i]);
        foreach (msg[i]) send_frame(msg[i], 1'b1);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (valid_cnt - v0 != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d strobes (%0d pending), required 6 (0)",
                     valid_cnt - v0, exp_q.size());
        end
    endtask

    task automatic test_glitch();
        int v0 = valid_cnt;
        int f0 = frame_cnt;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_high: got %b, required 1", busy);
        end
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid_cnt != v0 || frame_cnt != f0) begin
            errors++;
            $display("FAIL glitch_quiet: got busy=%b valid+%0d ferr+%0d, required 0 0 0",
                     busy, valid_cnt - v0, frame_cnt - f0);
        end
    endtask

    task automatic test_framing_error();
        int v0 = valid_cnt;
        int f0 = frame_cnt;
        send_frame(8'h41, 1'b0);
        repeat (2000) @(negedge clk);
        checks++;
        if (frame_cnt - f0 != 1 || valid_cnt != v0) begin
            errors++;
            $display("FAIL ferr_count: got ferr+%0d valid+%0d, required 1 0", frame_cnt - f0, valid_cnt - v0);
        end
        checks++;
        if (rx_data !== 8'h43 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_hold: got data=%02h busy=%b, required 43 0", rx_data, busy);
        end
        rx = 1'b1;
        repeat (100) @(negedge clk);
        exp_q.push_back(8'h56);
        send_frame(8'h56, 1'b1);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (valid_cnt - v0 != 1 || frame_cnt - f0 != 1) begin
            errors++;
            $display("FAIL ferr_recover: got valid+%0d ferr+%0d, required 1 1", valid_cnt - v0, frame_cnt - f0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0 = valid_cnt;
        int f0 = frame_cnt;
        logic [7:0] d = 8'h41;
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = d[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        checks++;
        if (rx_data !== 8'h00 || busy !== 1'b0 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: got data=%02h busy=%b valid=%b ferr=%b, required 00 0 0 0",
                     rx_data, busy, rx_valid, frame_err);
        end
        repeat (2000) @(negedge clk);
        checks++;
        if (valid_cnt != v0 || frame_cnt != f0) begin
            errors++;
            $display("FAIL midrst_quiet: got valid+%0d ferr+%0d, required 0 0", valid_cnt - v0, frame_cnt - f0);
        end
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (valid_cnt - v0 != 1 || rx_data !== 8'h41) begin
            errors++;
            $display("FAIL midrst_next: got valid+%0d data=%02h, required 1 41", valid_cnt - v0, rx_data);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0 = valid_cnt;
        int p0 = par_cnt;
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (valid_cnt - v0 != 1 || par_cnt != p0) begin
            errors++;
            $display("FAIL parity_good: got valid+%0d perr+%0d, required 1 0", valid_cnt - v0, par_cnt - p0);
        end
        par_flip = 1'b1;
        send_frame(8'h41, 1'b1);
        par_flip = 1'b0;
        rx = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (valid_cnt - v0 != 1 || par_cnt - p0 != 1) begin
            errors++;
            $display("FAIL parity_bad: got valid+%0d perr+%0d, required 1 1", valid_cnt - v0, par_cnt - p0);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d bytes pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
